// File: rtl/hram_txn_sequencer.sv
// HyperRAM command sequencer: one command at a time, CA build, engine launch/bus mux, CS# recovery; start 1 cycle after accept.
// cmd_ready only in IDLE; optional BUSY watchdog with engine abort enabled by HRAM_SEQ_TIMEOUT_EN.
module hram_txn_sequencer #(
  parameter int unsigned CSHI_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1023,
  parameter bit          WRREG_SUPPORTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  output logic        cmd_done,
  output logic [1:0]  cmd_status,
  output logic [47:0] casig,
  output logic [3:0]  eng_start,
  input  logic [3:0]  eng_end,
  output logic [3:0]  eng_rst,
  input  logic [3:0]  eng_oe,
  input  logic [3:0]  eng_oe_clk,
  input  logic [3:0]  eng_csn,
  input  logic [3:0]  eng_rwds_out,
  input  logic [3:0]  eng_rwds_oe,
  input  logic [63:0] eng_datain,
  output logic        bus_oe,
  output logic        bus_oe_clk,
  output logic        bus_csn,
  output logic        bus_rwds_out,
  output logic        bus_rwds_oe,
  output logic [15:0] bus_datain
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_BUSY, ST_RECOVER, ST_DONE
  } state_t;

  localparam logic [3:0] CSHI_LAST = 4'(CSHI_CYCLES - 1);

  // Out-of-range parameters leave this empty block elaborated as a marker.
  if (CSHI_CYCLES < 1 || CSHI_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2047)
  begin : g_param_out_of_range
  end

  state_t     state_q, state_d;
  logic [1:0] sel_q;
  logic [1:0] status_d;
  logic [3:0] rec_cnt_q;
  logic       accept;
  logic       timeout;

  always_comb begin
    state_d  = state_q;
    status_d = cmd_status;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_op == 2'd3 && !WRREG_SUPPORTED) begin
            state_d  = ST_DONE;
            status_d = 2'd2;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        // A same-cycle end pulse beats the watchdog.
        if (eng_end[sel_q]) begin
          state_d  = ST_RECOVER;
          status_d = 2'd0;
        end else if (timeout) begin
          state_d  = ST_RECOVER;
          status_d = 2'd1;
        end
      end
      ST_RECOVER: if (rec_cnt_q == CSHI_LAST) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      rec_cnt_q  <= 4'd0;
      cmd_ready  <= 1'b1;
      cmd_done   <= 1'b0;
      cmd_status <= 2'd0;
      casig      <= 48'd0;
      eng_start  <= 4'd0;
    end else begin
      state_q    <= state_d;
      cmd_status <= status_d;
      cmd_ready  <= (state_d == ST_IDLE);
      cmd_done   <= (state_d == ST_DONE);
      rec_cnt_q  <= (state_q == ST_RECOVER) ? rec_cnt_q + 4'd1 : 4'd0;
      eng_start  <= (accept && state_d == ST_LAUNCH) ? (4'(1) << cmd_op) : 4'd0;
      if (accept) begin
        sel_q <= cmd_op;
        casig <= {~cmd_op[0], cmd_op[1], 1'b1, cmd_addr[31:3], 13'd0, cmd_addr[2:0]};
      end
    end
  end

`ifdef HRAM_SEQ_TIMEOUT_EN
  localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT_CYCLES - 1);

  logic [10:0] busy_cnt_q;
  logic        rst_hold_q;
  logic        abort;

  assign timeout = (busy_cnt_q >= TIMEOUT_LAST);
  assign abort   = (state_q == ST_BUSY) && !eng_end[sel_q] && timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= 11'd0;
      rst_hold_q <= 1'b0;
      eng_rst    <= 4'd0;
    end else begin
      if (state_q != ST_BUSY)       busy_cnt_q <= 11'd0;
      else if (busy_cnt_q != 11'h7FF) busy_cnt_q <= busy_cnt_q + 11'd1;
      // Abort reset stays on for two cycles.
      if (abort) begin
        eng_rst    <= 4'(1) << sel_q;
        rst_hold_q <= 1'b1;
      end else if (rst_hold_q) begin
        rst_hold_q <= 1'b0;
      end else begin
        eng_rst <= 4'd0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign eng_rst = 4'd0;
`endif

  // Bus follows the registered selection only while BUSY; idle everywhere else.
  always_comb begin
    bus_oe       = 1'b0;
    bus_oe_clk   = 1'b0;
    bus_csn      = 1'b1;
    bus_rwds_out = 1'b0;
    bus_rwds_oe  = 1'b0;
    bus_datain   = 16'd0;
    if (state_q == ST_BUSY) begin
      bus_oe       = eng_oe[sel_q];
      bus_oe_clk   = eng_oe_clk[sel_q];
      bus_csn      = eng_csn[sel_q];
      bus_rwds_out = eng_rwds_out[sel_q];
      bus_rwds_oe  = eng_rwds_oe[sel_q];
      bus_datain   = eng_datain[{sel_q, 4'b0000} +: 16];
    end
  end

endmodule

// File: tb/tb_hram_txn_sequencer.sv
// Directed bench for hram_txn_sequencer: CA fields, launch, bus mux, recovery timing, unsupported op, reset abort, watchdog.
module tb_hram_txn_sequencer;
  localparam int CSHI = 4;
`ifdef HRAM_SEQ_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic        clk, rst, cmd_valid, cmd_ready, cmd_done;
  logic [1:0]  cmd_op, cmd_status;
  logic [31:0] cmd_addr;
  logic [47:0] casig;
  logic [3:0]  eng_start, eng_end, eng_rst;
  logic [3:0]  eng_oe, eng_oe_clk, eng_csn, eng_rwds_out, eng_rwds_oe;
  logic [63:0] eng_datain;
  logic        bus_oe, bus_oe_clk, bus_csn, bus_rwds_out, bus_rwds_oe;
  logic [15:0] bus_datain;
  logic [3:0]  bus_ctl;

  int checks = 0;
  int errors = 0;

  hram_txn_sequencer #(.CSHI_CYCLES(CSHI), .TIMEOUT_CYCLES(TO), .WRREG_SUPPORTED(1'b0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_done(cmd_done), .cmd_status(cmd_status), .casig(casig),
    .eng_start(eng_start), .eng_end(eng_end), .eng_rst(eng_rst), .eng_oe(eng_oe),
    .eng_oe_clk(eng_oe_clk), .eng_csn(eng_csn), .eng_rwds_out(eng_rwds_out),
    .eng_rwds_oe(eng_rwds_oe), .eng_datain(eng_datain), .bus_oe(bus_oe),
    .bus_oe_clk(bus_oe_clk), .bus_csn(bus_csn), .bus_rwds_out(bus_rwds_out),
    .bus_rwds_oe(bus_rwds_oe), .bus_datain(bus_datain)
  );

  assign bus_ctl = {bus_oe, bus_oe_clk, bus_rwds_out, bus_rwds_oe};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has already passed the eng_end edge; counts further edges to cmd_done.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cmd_done && n < 40);
  endtask

  int n, hi, done_at, start_at, pulses;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'd0; eng_end = 4'd0;
    eng_oe = 4'b0101; eng_oe_clk = 4'b0011; eng_csn = 4'b0000;
    eng_rwds_out = 4'b1001; eng_rwds_oe = 4'b0110;
    eng_datain = 64'hDDDD_CCCC_BBBB_AAAA;
    step(); step();
    check("rst_ready", cmd_ready, 1);
    check("rst_done", cmd_done, 0);
    check("rst_status", cmd_status, 0);
    check("rst_casig", casig, 0);
    check("rst_start", eng_start, 0);
    check("rst_engrst", eng_rst, 0);
    check("rst_csn", bus_csn, 1);
    check("rst_ctl", bus_ctl, 0);
    check("rst_dq", bus_datain, 0);
    rst = 1'b0;

    // op 0, addr 0x1234
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h0000_1234;
    step();
    check("t1_ca_hi", casig[47:45], 3'b101);
    check("t1_ca_addr", casig[44:16], 29'h246);
    check("t1_ca_zero", casig[15:3], 0);
    check("t1_ca_lo", casig[2:0], 3'd4);
    check("t1_start", eng_start, 4'b0001);
    check("t1_ready", cmd_ready, 0);
    check("t1_launch_csn", bus_csn, 1);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF;
    step();
    check("t1_start_off", eng_start, 0);
    check("t1_busy_csn", bus_csn, 0);
    check("t1_busy_ctl", bus_ctl, 4'b1110);
    check("t1_busy_dq", bus_datain, 16'hAAAA);
    check("t1_ca_hold", casig[44:16], 29'h246);
    step(); step();
    eng_end = 4'b0001;
    step();
    eng_end = 4'b0000;
    check("t1_rec_csn", bus_csn, 1);
    check("t1_rec_ctl", bus_ctl, 0);
    wait_done(n);
    check("t1_end_to_done", n + 1, CSHI + 1);
    check("t1_status", cmd_status, 0);
    step();
    check("t1_ready_back", cmd_ready, 1);
    check("t1_done_off", cmd_done, 0);

    // op 2, addr 0, spurious end from engine 1
    eng_csn = 4'b1011;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 32'd0;
    step();
    cmd_valid = 1'b0;
    check("t2_casig", casig, 48'hE000_0000_0000);
    check("t2_start", eng_start, 4'b0100);
    step();
    check("t2_csn", bus_csn, 0);
    check("t2_ctl", bus_ctl, 4'b1001);
    check("t2_dq", bus_datain, 16'hCCCC);
    eng_end = 4'b0010;
    step();
    eng_end = 4'b0000;
    check("t2_spur_done", cmd_done, 0);
    check("t2_spur_csn", bus_csn, 0);
    eng_csn = 4'b1111;
    #1;
    check("t2_mirror_hi", bus_csn, 1);
    eng_csn = 4'b1011;
    step();
    check("t2_still_busy", bus_csn, 0);
    eng_end = 4'b0100;
    step();
    eng_end = 4'b0000;
    wait_done(n);
    check("t2_end_to_done", n + 1, CSHI + 1);
    check("t2_status", cmd_status, 0);
    step();

    // op 3 unsupported
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = 32'h8;
    step();
    cmd_valid = 1'b0;
    check("t3_done", cmd_done, 1);
    check("t3_status", cmd_status, 2);
    check("t3_start", eng_start, 0);
    check("t3_csn", bus_csn, 1);
    check("t3_ca_hi", casig[47:45], 3'b011);
    step();
    check("t3_ready", cmd_ready, 1);
    check("t3_done_off", cmd_done, 0);
    check("t3_start_off", eng_start, 0);

    // back-to-back: op 1 then op 0 with cmd_valid held
    eng_csn = 4'b0000;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 32'h10;
    step();
    check("t4_start1", eng_start, 4'b0010);
    cmd_op = 2'd0; cmd_addr = 32'h20;
    step();
    check("t4_held_ignored", eng_start, 0);
    check("t4_busy_csn", bus_csn, 0);
    eng_end = 4'b0010;
    hi = 0; done_at = -1; start_at = -1;
    for (int i = 0; i < 30 && start_at < 0; i++) begin
      step();
      eng_end = 4'b0000;
      if (bus_csn) hi++;
      if (cmd_done) done_at = i;
      if (eng_start != 0) start_at = i;
    end
    cmd_valid = 1'b0;
    check("t4_done_at", done_at, CSHI);
    check("t4_accept_gap", start_at - done_at, 2);
    check("t4_csn_hi_min", hi >= CSHI, 1);
    check("t4_start2", eng_start, 4'b0001);
    check("t4_ca2", casig[44:16], 29'h4);
    step();
    check("t4_busy2_csn", bus_csn, 0);
    eng_end = 4'b0001;
    step();
    eng_end = 4'b0000;
    wait_done(n);
    check("t4_end_to_done", n + 1, CSHI + 1);
    step();

    // reset in the middle of BUSY
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h4;
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("t5_busy_csn", bus_csn, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_csn", bus_csn, 1);
    check("t5_ready", cmd_ready, 1);
    check("t5_casig", casig, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_done) pulses++;
    end
    check("t5_no_done", pulses, 0);

`ifdef HRAM_SEQ_TIMEOUT_EN
    // engine 1 never ends
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 32'd0;
    step();
    cmd_valid = 1'b0;
    step();
    n = 1;
    while (eng_rst == 0 && n < 60) begin
      step();
      n++;
    end
    check("t6_busy_cycles", n - 1, TO);
    check("t6_engrst", eng_rst, 4'b0010);
    check("t6_csn", bus_csn, 1);
    step();
    check("t6_engrst2", eng_rst, 4'b0010);
    step();
    check("t6_engrst_off", eng_rst, 0);
    n = 0;
    while (!cmd_done && n < 40) begin
      step();
      n++;
    end
    check("t6_to_done", n, CSHI - 2);
    check("t6_status", cmd_status, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
